// File: rtl/cmp_mux_pkg.sv
// Shared definitions for the comparator_mux sweeper: FSM states, mode_sel
// encodings and the reference contract model used by RTL and benches.
package cmp_mux_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUX_SWEEP,
    S_CMP_SWEEP,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_MUX  = 2'b01;
  localparam logic [1:0] MODE_CMP  = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // Widest bus the contract model handles; callers zero-extend and truncate.
  localparam int MAX_W = 32;

  function automatic logic [MAX_W-1:0] cmp_mux_expected(
    input logic [MAX_W-1:0] data,
    input logic [MAX_W-1:0] compare,
    input logic             control
  );
    if (control && (compare > data)) return compare;
    return data;
  endfunction

endpackage

// File: rtl/cmp_mux_expect_pipe.sv
// Fixed-depth delay line that carries each driven vector and its expected
// response so the check lines up with a pipelined DUT. Depth 0 passes through.
module cmp_mux_expect_pipe
  import cmp_mux_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_expected_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic [DATA_WIDTH-1:0] in_compare_i,
  input  logic                  in_control_i,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_expected_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [DATA_WIDTH-1:0] out_compare_o,
  output logic                  out_control_o
);

  localparam int ENT_W = 3 * DATA_WIDTH + 2;

  logic [ENT_W-1:0] ent_in;
  logic [ENT_W-1:0] ent_out;

  assign ent_in = {in_valid_i, in_expected_i, in_data_i, in_compare_i, in_control_i};

  generate
    if (DEPTH == 0) begin : g_pass
      assign ent_out = ent_in;
    end else begin : g_dly
      logic [ENT_W-1:0] stage_q [DEPTH];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= ent_in;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign ent_out = stage_q[DEPTH-1];
    end
  endgenerate

  assign {out_valid_o, out_expected_o, out_data_o, out_compare_o, out_control_o} = ent_out;

endmodule

// File: rtl/cmp_mux_sweeper.sv
// Exhaustive stimulus/response engine for a comparator_mux: sweeps mux then
// compare vectors, checks mux_output after RESP_LATENCY, logs first failure.
module cmp_mux_sweeper
  import cmp_mux_pkg::*;
#(
  parameter int DATA_WIDTH   = 4,
  parameter int RESP_LATENCY = 0,
  parameter int ERR_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            mode_sel,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] drv_data,
  output logic [DATA_WIDTH-1:0] drv_compare,
  output logic                  drv_control,
  input  logic [DATA_WIDTH-1:0] dut_out,
  output logic [ERR_W-1:0]      err_count,
  output logic                  first_err_valid,
  output logic [DATA_WIDTH-1:0] first_err_data,
  output logic [DATA_WIDTH-1:0] first_err_compare,
  output logic                  first_err_control
);

  localparam int CNT_W = 2 * DATA_WIDTH;

  state_t                  state_q, state_d, after_sweep;
  logic                    cmp_pending_q, cmp_pending_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   drv_data_q, drv_compare_q;
  logic [DATA_WIDTH-1:0]   drv_data_d, drv_compare_d;
  logic                    drv_control_q, drv_control_d;
  logic                    vec_valid_q, vec_valid_d;
  logic [ERR_W-1:0]        err_q;
  logic                    fe_valid_q, fe_control_q;
  logic [DATA_WIDTH-1:0]   fe_data_q, fe_compare_q;
  logic [DATA_WIDTH-1:0]   expected_now;
  logic                    chk_valid, chk_control, mismatch;
  logic [DATA_WIDTH-1:0]   chk_expected, chk_data, chk_compare;

  assign after_sweep = (RESP_LATENCY == 0) ? S_DONE : S_DRAIN;

  always_comb begin
    state_d       = state_q;
    cmp_pending_d = cmp_pending_q;
    cnt_d         = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cmp_pending_d = mode_sel[1];
          cnt_d         = '0;
          case (mode_sel)
            MODE_MUX, MODE_BOTH: state_d = S_MUX_SWEEP;
            MODE_CMP:            state_d = S_CMP_SWEEP;
            default:             state_d = S_DONE;
          endcase
        end
      end
      S_MUX_SWEEP: begin
        if (cnt_q[DATA_WIDTH-1:0] == '1) begin
          cnt_d   = '0;
          state_d = cmp_pending_q ? S_CMP_SWEEP : after_sweep;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CMP_SWEEP: begin
        // Full-width wrap leaves the counter at 0, ready to time DRAIN.
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == '1) state_d = after_sweep;
      end
      S_DRAIN: begin
        if (cnt_q == CNT_W'(RESP_LATENCY - 1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Drive registers are loaded from the next state so the DUT sees clean flops.
  always_comb begin
    vec_valid_d   = (state_d == S_MUX_SWEEP) || (state_d == S_CMP_SWEEP);
    drv_control_d = (state_d == S_CMP_SWEEP);
    drv_data_d    = vec_valid_d ? cnt_d[DATA_WIDTH-1:0] : '0;
    drv_compare_d = drv_control_d ? cnt_d[CNT_W-1:DATA_WIDTH] : '0;
  end

  assign expected_now = DATA_WIDTH'(cmp_mux_expected(MAX_W'(drv_data_q),
                                                     MAX_W'(drv_compare_q),
                                                     drv_control_q));

  cmp_mux_expect_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RESP_LATENCY)
  ) u_pipe (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid_i     (vec_valid_q),
    .in_expected_i  (expected_now),
    .in_data_i      (drv_data_q),
    .in_compare_i   (drv_compare_q),
    .in_control_i   (drv_control_q),
    .out_valid_o    (chk_valid),
    .out_expected_o (chk_expected),
    .out_data_o     (chk_data),
    .out_compare_o  (chk_compare),
    .out_control_o  (chk_control)
  );

  assign mismatch = chk_valid && (dut_out != chk_expected);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cmp_pending_q <= 1'b0;
      cnt_q         <= '0;
      drv_data_q    <= '0;
      drv_compare_q <= '0;
      drv_control_q <= 1'b0;
      vec_valid_q   <= 1'b0;
      err_q         <= '0;
      fe_valid_q    <= 1'b0;
      fe_data_q     <= '0;
      fe_compare_q  <= '0;
      fe_control_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmp_pending_q <= cmp_pending_d;
      cnt_q         <= cnt_d;
      drv_data_q    <= drv_data_d;
      drv_compare_q <= drv_compare_d;
      drv_control_q <= drv_control_d;
      vec_valid_q   <= vec_valid_d;
      if (state_q == S_IDLE && start) begin
        err_q        <= '0;
        fe_valid_q   <= 1'b0;
        fe_data_q    <= '0;
        fe_compare_q <= '0;
        fe_control_q <= 1'b0;
      end else if (mismatch) begin
        if (err_q != '1) err_q <= err_q + ERR_W'(1);
        if (!fe_valid_q) begin
          fe_valid_q   <= 1'b1;
          fe_data_q    <= chk_data;
          fe_compare_q <= chk_compare;
          fe_control_q <= chk_control;
        end
      end
    end
  end

  assign busy              = (state_q != S_IDLE);
  assign done              = (state_q == S_DONE);
  assign drv_data          = drv_data_q;
  assign drv_compare       = drv_compare_q;
  assign drv_control       = drv_control_q;
  assign err_count         = err_q;
  assign first_err_valid   = fe_valid_q;
  assign first_err_data    = fe_data_q;
  assign first_err_compare = fe_compare_q;
  assign first_err_control = fe_control_q;

endmodule

// File: tb/tb_cmp_mux_sweeper.sv
// Scoreboard bench: two sweepers (combinational DUT model / 2-stage registered
// DUT model with a narrow error counter) share stimulus; a monitor checks each done.
module tb_cmp_mux_sweeper;
  import cmp_mux_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, fault;
  logic [1:0] mode_sel;

  logic        busy0, done0, drv_ctl0, fv0, fctl0;
  logic [3:0]  drv_data0, drv_cmp0, dut_out0, fd0, fc0;
  logic [15:0] err0;

  logic        busy1, done1, drv_ctl1, fv1, fctl1;
  logic [3:0]  drv_data1, drv_cmp1, dut_out1, fd1, fc1;
  logic [2:0]  err1;

  // Reference comparator_mux with optional output bit0 stuck-at-0.
  function automatic logic [3:0] ref_out(input logic [3:0] d, input logic [3:0] c,
                                         input logic ctl, input logic flt);
    logic [3:0] r;
    r = (ctl && c > d) ? c : d;
    if (flt) r[0] = 1'b0;
    return r;
  endfunction

  assign dut_out0 = ref_out(drv_data0, drv_cmp0, drv_ctl0, fault);

  logic [3:0] p1_q, p2_q;
  always @(posedge clk) begin
    p1_q <= ref_out(drv_data1, drv_cmp1, drv_ctl1, fault);
    p2_q <= p1_q;
  end
  assign dut_out1 = p2_q;

  cmp_mux_sweeper #(.DATA_WIDTH(4), .RESP_LATENCY(0), .ERR_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_sel(mode_sel),
    .busy(busy0), .done(done0), .drv_data(drv_data0), .drv_compare(drv_cmp0),
    .drv_control(drv_ctl0), .dut_out(dut_out0), .err_count(err0),
    .first_err_valid(fv0), .first_err_data(fd0), .first_err_compare(fc0),
    .first_err_control(fctl0)
  );

  cmp_mux_sweeper #(.DATA_WIDTH(4), .RESP_LATENCY(2), .ERR_W(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_sel(mode_sel),
    .busy(busy1), .done(done1), .drv_data(drv_data1), .drv_compare(drv_cmp1),
    .drv_control(drv_ctl1), .dut_out(dut_out1), .err_count(err1),
    .first_err_valid(fv1), .first_err_data(fd1), .first_err_compare(fc1),
    .first_err_control(fctl1)
  );

  typedef struct {
    int         lat;
    int         t0;
    int         err;
    logic       fv;
    logic [3:0] fd;
    logic [3:0] fc;
    logic       fctl;
    logic [2:0] hist;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [2:0] hist0 = '0, hist1 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse; hist* records whether drv_*
  // was non-zero in each of the last three cycles, exposing drain length.
  always @(negedge clk) begin
    exp_t e;
    if (done0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0_unexpected_done at cycle %0d", cyc);
      end else begin
        e = q0.pop_front();
        $display("dut0 done: lat=%0d err=%0d fv=%0d fd=%0d fc=%0d fctl=%0d",
                 cyc - e.t0 + 1, err0, fv0, fd0, fc0, fctl0);
        chk("dut0_latency", cyc - e.t0 + 1, e.lat);
        chk("dut0_err_count", err0, e.err);
        chk("dut0_first_valid", fv0, e.fv);
        chk("dut0_first_data", fd0, e.fd);
        chk("dut0_first_compare", fc0, e.fc);
        chk("dut0_first_control", fctl0, e.fctl);
        chk("dut0_drv_history", hist0, e.hist);
      end
    end
    if (done1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1_unexpected_done at cycle %0d", cyc);
      end else begin
        e = q1.pop_front();
        $display("dut1 done: lat=%0d err=%0d fv=%0d fd=%0d fc=%0d fctl=%0d",
                 cyc - e.t0 + 1, err1, fv1, fd1, fc1, fctl1);
        chk("dut1_latency", cyc - e.t0 + 1, e.lat);
        chk("dut1_err_count", err1, e.err);
        chk("dut1_first_valid", fv1, e.fv);
        chk("dut1_first_data", fd1, e.fd);
        chk("dut1_first_compare", fc1, e.fc);
        chk("dut1_first_control", fctl1, e.fctl);
        chk("dut1_drain_history", hist1, e.hist);
      end
    end
    hist0 = {hist0[1:0], |{drv_data0, drv_cmp0, drv_ctl0}};
    hist1 = {hist1[1:0], |{drv_data1, drv_cmp1, drv_ctl1}};
  end

  task automatic wait_idle();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || busy0 || busy1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL sweep_timeout: %0d/%0d expectations still pending", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Issue a sweep at a negedge; e0/e1 are hand-computed error counts.
  task automatic run(input logic [1:0] m, input logic flt, input int vecs,
                     input int e0, input int e1, input logic fv, input logic [3:0] fd,
                     input logic [3:0] fc, input logic fctl, input int hold);
    fault    = flt;
    mode_sel = m;
    start    = 1'b1;
    q0.push_back('{lat: vecs + 1, t0: cyc + 1, err: e0, fv: fv, fd: fd, fc: fc,
                   fctl: fctl, hist: (vecs != 0) ? 3'b111 : 3'b000});
    q1.push_back('{lat: (vecs != 0) ? vecs + 3 : 1, t0: cyc + 1, err: e1, fv: fv,
                   fd: fd, fc: fc, fctl: fctl, hist: (vecs != 0) ? 3'b100 : 3'b000});
    repeat (hold) @(negedge clk);
    start = 1'b0;
    wait_idle();
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy0"}, busy0, 0);
    chk({tag, "_busy1"}, busy1, 0);
    chk({tag, "_done0"}, done0, 0);
    chk({tag, "_drv0"}, {drv_data0, drv_cmp0, drv_ctl0}, 0);
    chk({tag, "_drv1"}, {drv_data1, drv_cmp1, drv_ctl1}, 0);
    chk({tag, "_err0"}, err0, 0);
    chk({tag, "_err1"}, err1, 0);
    chk({tag, "_first0"}, {fv0, fd0, fc0, fctl0}, 0);
    chk({tag, "_first1"}, {fv1, fd1, fc1, fctl1}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; mode_sel = MODE_NONE; fault = 1'b0;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst_n = 1'b1;
    @(negedge clk);

    //  mode       fault vecs e0   e1 fv  fd    fc    fctl hold
    run(MODE_BOTH, 1'b0, 272, 0,   0, 0, 4'd0, 4'd0, 0,   1);
    run(MODE_MUX,  1'b1, 16,  8,   7, 1, 4'd1, 4'd0, 0,   1);
    run(MODE_CMP,  1'b1, 256, 136, 7, 1, 4'd1, 4'd0, 1,   1);
    run(MODE_BOTH, 1'b1, 272, 144, 7, 1, 4'd1, 4'd0, 0,   1);
    // start still high in the DONE cycle must not relaunch
    run(MODE_NONE, 1'b1, 0,   0,   0, 0, 4'd0, 4'd0, 0,   2);
    chk("mode00_no_restart", {busy0, busy1}, 0);
    // start held for 10 cycles while busy must not restart
    run(MODE_MUX,  1'b0, 16,  0,   0, 0, 4'd0, 4'd0, 0,   10);

    // Reset in the 5th MUX_SWEEP cycle aborts without a done pulse.
    fault = 1'b1; mode_sel = MODE_MUX; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_err0", err0, 2);
    chk("pre_reset_err1", err1, 1);
    chk("pre_reset_drv0", drv_data0, 4);
    rst_n = 1'b0;
    @(negedge clk);
    chk_quiet("midreset");
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_reset_idle", {busy0, busy1}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmp_mux_sweeper.md
Name: cmp_mux_sweeper

Overview:
Synthesizable stimulus/response engine that sits on the driving side of a comparator_mux instance. It sweeps the DUT's input space exhaustively, samples mux_output after a fixed response latency, and checks each sample against the comparator_mux contract. It reports error count and first-failure context. Used for on-chip self-test and as the bench-side driver in regressions.

Parameters:
DATA_WIDTH, 4, width of data/compare/output buses
RESP_LATENCY, 0, clock cycles from driven vector to valid dut_out (0 = combinational DUT)
ERR_W, 16, width of saturating error counter

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  request a sweep; accepted only in IDLE
mode_sel  in  2  01 = mux sweep only, 10 = compare sweep only, 11 = both (mux then compare), 00 = no vectors
busy  out  1  high from start acceptance until the cycle after done
done  out  1  one-cycle pulse at sweep completion
drv_data  out  DATA_WIDTH  to DUT data_input
drv_compare  out  DATA_WIDTH  to DUT compare_value
drv_control  out  1  to DUT control
dut_out  in  DATA_WIDTH  from DUT mux_output
err_count  out  ERR_W  mismatches in the last sweep, saturating
first_err_valid  out  1  a mismatch has been captured since start
first_err_data  out  DATA_WIDTH  drv_data of the first failing vector
first_err_compare  out  DATA_WIDTH  drv_compare of the first failing vector
first_err_control  out  1  drv_control of the first failing vector

Behaviour:
- DUT contract: control=0 -> expected = data_input; control=1 -> expected = max(data_input, compare_value), unsigned.
- Reset (rst_n=0 at clk edge): state IDLE; all outputs 0, including drv_*, err_count, first_err_*, busy and done; pipeline flushed. Reset mid-sweep aborts the sweep with no done pulse.
- FSM states: IDLE, MUX_SWEEP, CMP_SWEEP, DRAIN, DONE.
- IDLE: drv_* = 0. start=1 latches mode_sel, clears err_count and first_err_*, sets busy, and moves to MUX_SWEEP (bit0 set), CMP_SWEEP (only bit1 set), or DONE (00).
- MUX_SWEEP: drv_control=0, drv_compare=0, drv_data counts 0..2^W-1, one vector per cycle. After the last vector: CMP_SWEEP if mode bit1 set, else DRAIN (DONE if RESP_LATENCY=0).
- CMP_SWEEP: drv_control=1. drv_compare is the outer loop and drv_data the inner loop, each 0..2^W-1, giving 2^(2W) vectors. The vector counter is 2*DATA_WIDTH bits and wraps to 0 at the end. Next state is DRAIN, or DONE if RESP_LATENCY=0.
- DRAIN: drv_* = 0. Lasts exactly RESP_LATENCY cycles so that in-flight checks retire, then moves to DONE.
- DONE: done=1 for one cycle, then IDLE. busy drops in the IDLE cycle that follows. A start asserted in the DONE cycle is ignored.
- Checking: each driven vector's {expected, data, compare, control, valid} enters a RESP_LATENCY-deep delay line. dut_out is compared against the delay-line output in the same cycle. With RESP_LATENCY=0 the compare uses the current registered drv_* values. Only valid entries are checked; DRAIN and IDLE entries are invalid.
- On a mismatch: err_count increments and saturates at 2^ERR_W-1. On the first mismatch, first_err_* capture the vector and first_err_valid sets.
- err_count and first_err_* hold after done until the next accepted start.
- start asserted while busy is ignored.
- Total cycles from start acceptance (cycle T) to the done pulse = vectors + RESP_LATENCY + 1. With mode 11 and W=4, done is at T+273+RESP_LATENCY.

Decomposition:
- Package cmp_mux_pkg holds:
  - the state enum;
  - the mode_sel encodings (MODE_NONE, MODE_MUX, MODE_CMP, MODE_BOTH);
  - function cmp_mux_expected(data, compare, control), the contract model shared with benches.
- One sub-module, cmp_mux_expect_pipe: a parameterized RESP_LATENCY-deep delay line of {valid, expected, data, compare, control}. At depth 0 it is a pass-through.

Test Plan:
- Correct combinational DUT, mode 11, RESP_LATENCY=0 -> done at T+273, err_count=0, first_err_valid=0.
- DUT output bit0 stuck-at-0, mode 01 -> err_count=8; first_err data=1, compare=0, control=0.
- Same fault, mode 10 -> err_count=136 (odd max values); first_err data=1, compare=0, control=1.
- ERR_W=3, same fault, mode 11 -> err_count saturates at 7; first_err data=1, control=0.
- RESP_LATENCY=2 with a 2-stage registered correct DUT, mode 11 -> err_count=0, done at T+275, drv_*=0 during the 2 DRAIN cycles.
- rst_n low at the 5th MUX_SWEEP cycle -> next cycle busy=0, drv_*=0, err_count=0, no done pulse. start with mode 00 -> done at T+1, err_count=0. start held during busy -> no restart.
